flow_level_monitor: RTL and testbench
=====================================

Name: flow_level_monitor

Overview:
- Next-generation flow-meter level block, parametrised in counter width, number of levels, level step, window length and alarm band.
- Replaces the static 5-bit level decoder with a time-based measurement path. Counts raw sensor pulses over a fixed clock window to produce flow_rate.
- Decodes flow_rate into a thermometer level bus y with hysteresis, a band flag z, and a persistence-qualified band alarm z_alarm.
- Sits between the flow-sensor pin and the display/valve-control logic.

Parameters:
- RATE_W, 8: width of flow_rate and of the pulse counter.
- LEVELS, 5: number of y outputs.
- STEP, 10: level spacing. Level i threshold is T_i = (i+1)*STEP.
- WINDOW, 1000: measurement window length in clk cycles. Must be >= 2.
- Z_LO, 20: lower band bound, inclusive.
- Z_HI, 50: upper band bound, exclusive.
- HYST, 2: clear hysteresis for y. Must be < STEP.
- ALARM_WINDOWS, 3: number of consecutive in-band windows needed to raise z_alarm. Must be >= 1.
- Legal configurations also satisfy LEVELS*STEP <= 2^RATE_W-1 and Z_LO < Z_HI.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- en  in  1  measurement enable.
- sensor_pulse  in  1  raw sensor pulse, asynchronous to clk.
- flow_rate  out  RATE_W  pulse count of the last completed window.
- rate_valid  out  1  one-cycle strobe: a new flow_rate is available.
- overflow  out  1  last completed window saturated the counter.
- y  out  LEVELS  thermometer level bus; y[i] means flow >= T_i.
- z  out  1  last flow_rate is in [Z_LO, Z_HI).
- z_alarm  out  1  z has held for ALARM_WINDOWS consecutive windows.

Behaviour:
- Reset (rst_n=0, takes effect asynchronously):
  - All outputs go to 0.
  - Synchroniser, edge detector, window counter, pulse counter and alarm counter all clear to 0.
  - State goes to IDLE.
- Input path:
  - sensor_pulse passes through a 2-FF synchroniser, then a rising-edge detect register.
  - An edge is recognised 3 clk after the first sampling edge at which sensor_pulse is high.
  - Each pulse must be high >= 2 clk and low >= 2 clk; shorter pulses may be lost.
- State machine:
  - IDLE: counters held at 0, outputs hold their last values, rate_valid=0. Move to COUNT when en=1.
  - COUNT: window counter runs 0..WINDOW-1. Each recognised edge increments the pulse counter, which saturates at 2^RATE_W-1 and sets an internal sat flag.
  - COUNT, en=0: window aborted, return to IDLE. No update and no rate_valid.
  - COUNT, at window count WINDOW-1: an edge recognised in that cycle still counts for the closing window.
- On the clock edge that ends cycle WINDOW-1, all of the following update together:
  - flow_rate gets the final count; overflow gets the sat flag.
  - Each y[i] is set if count >= T_i, cleared if count < T_i-HYST, otherwise holds.
  - z gets (count >= Z_LO && count < Z_HI).
  - The alarm counter increments (saturating at ALARM_WINDOWS) if the new z=1, else clears to 0.
  - z_alarm gets (new alarm count == ALARM_WINDOWS).
  - rate_valid is 1 for exactly this one cycle.
- Back-to-back windows:
  - Pulse counter, sat flag and window counter restart at 0 in the same edge.
  - There is no dead cycle between windows.
- Arithmetic:
  - Threshold compares are unsigned, at RATE_W+1 bits.
  - T_i-HYST cannot underflow because HYST < STEP.
- Boundaries:
  - count == T_i sets y[i].
  - count == Z_HI gives z=0; count == Z_LO gives z=1.
  - Saturated count gives flow_rate = all ones and overflow=1.
- Reset mid-window: the partial count is discarded, and the first full window starts after rst_n deasserts (with en=1).

Test Plan:
- WINDOW=256, defaults: 5 pulses in a window -> flow_rate=5, y=00000, z=0, rate_valid high 1 cycle at window end. Then 12 pulses -> y=00001, z=0.
- Next window 25 pulses -> y=00011, z=1, z_alarm=0. Two more windows of 25 -> z_alarm rises with the 3rd rate_valid.
- From y=00011: window of 19 -> y=00011 (holds, 19 >= 18). Then 17 -> y=00001. Then 55 -> y=11111, z=0, z_alarm=0. Then 50 -> z=0; then 20 -> z=1.
- WINDOW=1100, RATE_W=8: 260 pulses -> flow_rate=255, overflow=1. Next window of 10 pulses -> flow_rate=10, overflow=0.
- en dropped at cycle 100 of a window -> no rate_valid and all outputs hold. en reasserted -> a full 256-cycle window elapses before the next rate_valid.
- rst_n pulsed low mid-window while y=11111 and z_alarm=1 -> all outputs 0 immediately with no clk edge needed. Pulses before reset are not counted.

Source files
------------

// File: rtl/flow_level_monitor.sv
// flow_level_monitor: counts sensor pulses per clock window and decodes the rate into
// a hysteretic thermometer level, a band flag and a persistence-qualified band alarm.
module flow_level_monitor #(
  parameter int RATE_W = 8,
  parameter int LEVELS = 5,
  parameter int STEP = 10,
  parameter int WINDOW = 1000,
  parameter int Z_LO = 20,
  parameter int Z_HI = 50,
  parameter int HYST = 2,
  parameter int ALARM_WINDOWS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sensor_pulse,
  output logic [RATE_W-1:0] flow_rate,
  output logic              rate_valid,
  output logic              overflow,
  output logic [LEVELS-1:0] y,
  output logic              z,
  output logic              z_alarm
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam int AL_W = $clog2(ALARM_WINDOWS + 1);
  localparam logic [0:0] IDLE = 1'b0, COUNT = 1'b1;
  logic [2:0] r_sync;
  logic r_edge;
  logic [0:0] r_state;
  logic [WIN_W-1:0] r_win;
  logic [RATE_W-1:0] r_cnt, r_rate;
  logic r_sat, r_valid, r_ovf, r_z, r_za;
  logic [AL_W-1:0] r_alarm;
  logic [LEVELS-1:0] r_y, w_y;
  logic w_full, w_sat, w_last, w_run, w_close, w_z;
  logic [RATE_W-1:0] w_cnt;
  logic [RATE_W:0] w_ext;
  logic [AL_W-1:0] w_alarm;
  assign w_full = r_cnt == '1;
  assign w_cnt = (r_edge && !w_full) ? r_cnt + 1'b1 : r_cnt;
  assign w_sat = r_sat | (r_edge & w_full);
  assign w_ext = {1'b0, w_cnt};
  assign w_last = r_win == WIN_W'(WINDOW - 1);
  assign w_run = r_state == COUNT && en && !w_last;
  assign w_close = r_state == COUNT && en && w_last;
  assign w_z = w_ext >= (RATE_W+1)'(Z_LO) && w_ext < (RATE_W+1)'(Z_HI);
  assign w_alarm = !w_z ? '0 : (r_alarm == AL_W'(ALARM_WINDOWS)) ? r_alarm : r_alarm + 1'b1;
  // Between the set and clear thresholds each level keeps its previous value.
  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    assign w_y[i] = (w_ext >= (RATE_W+1)'((i + 1) * STEP)) ? 1'b1 :
                    (w_ext < (RATE_W+1)'((i + 1) * STEP - HYST)) ? 1'b0 : r_y[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
      r_state <= IDLE;
      r_win <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_alarm <= '0;
      r_rate <= '0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
      r_y <= '0;
      r_z <= 1'b0;
      r_za <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], sensor_pulse};
      r_edge <= r_sync[1] & ~r_sync[2];
      r_state <= en ? COUNT : IDLE;
      r_win <= w_run ? r_win + 1'b1 : '0;
      r_cnt <= w_run ? w_cnt : '0;
      r_sat <= w_run ? w_sat : 1'b0;
      r_valid <= w_close;
      if (w_close) begin
        r_rate <= w_cnt;
        r_ovf <= w_sat;
        r_y <= w_y;
        r_z <= w_z;
        r_alarm <= w_alarm;
        r_za <= w_alarm == AL_W'(ALARM_WINDOWS);
      end
    end
  end
  assign flow_rate = r_rate;
  assign rate_valid = r_valid;
  assign overflow = r_ovf;
  assign y = r_y;
  assign z = r_z;
  assign z_alarm = r_za;
endmodule

// File: tb/tb_flow_level_monitor.sv
// tb_flow_level_monitor: directed windows of sensor pulses against hand-computed rate,
// level, band, alarm and overflow values on a 256-cycle and a 1100-cycle instance.
module tb_flow_level_monitor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0, p_a = 1'b0, p_b = 1'b0;
  logic [7:0] rate_a, rate_b;
  logic rv_a, rv_b, ov_a, ov_b, z_a, z_b, za_a, za_b;
  logic [4:0] y_a, y_b;
  int n_chk = 0, n_pass = 0;
  time t_rv, t_en;
  flow_level_monitor #(.WINDOW(256)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .sensor_pulse(p_a), .flow_rate(rate_a),
    .rate_valid(rv_a), .overflow(ov_a), .y(y_a), .z(z_a), .z_alarm(za_a));
  flow_level_monitor #(.WINDOW(1100)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .sensor_pulse(p_b), .flow_rate(rate_b),
    .rate_valid(rv_b), .overflow(ov_b), .y(y_b), .z(z_b), .z_alarm(za_b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic pulses(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) p_b = 1'b1; else p_a = 1'b1;
      repeat (2) @(negedge clk);
      if (b) p_b = 1'b0; else p_a = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask
  task automatic win(input bit b, input int n, input int er, input logic [4:0] ey,
                     input logic ez, input logic eza, input logic eov);
    bit got = 0;
    string t = $sformatf("%s_n%0d", b ? "b" : "a", n);
    pulses(b, n);
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = b ? rv_b : rv_a;
    end
    t_rv = $time;
    check({t, " rate_valid"}, 32'(got), 1);
    check({t, " flow_rate"}, b ? rate_b : rate_a, er);
    check({t, " y"}, b ? y_b : y_a, ey);
    check({t, " z"}, b ? z_b : z_a, ez);
    check({t, " z_alarm"}, b ? za_b : za_a, eza);
    check({t, " overflow"}, b ? ov_b : ov_a, eov);
    @(negedge clk);
    check({t, " rate_valid one cycle"}, b ? rv_b : rv_a, 0);
  endtask
  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("reset flow_rate", rate_a, 0);
    check("reset y", y_a, 0);
    check("reset rate_valid", rv_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    en_a = 1'b1;
    win(0, 5, 5, 5'b00000, 0, 0, 0);
    win(0, 12, 12, 5'b00001, 0, 0, 0);
    win(0, 25, 25, 5'b00011, 1, 0, 0);
    win(0, 25, 25, 5'b00011, 1, 0, 0);
    win(0, 25, 25, 5'b00011, 1, 1, 0);
    win(0, 19, 19, 5'b00011, 0, 0, 0);
    win(0, 17, 17, 5'b00001, 0, 0, 0);
    win(0, 55, 55, 5'b11111, 0, 0, 0);
    win(0, 50, 50, 5'b11111, 0, 0, 0);
    win(0, 20, 20, 5'b00011, 1, 0, 0);
    repeat (99) @(negedge clk);
    en_a = 1'b0;
    seen = 0;
    pulses(0, 5);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      seen |= rv_a;
    end
    check("abort rate_valid", 32'(seen), 0);
    check("abort flow_rate hold", rate_a, 20);
    check("abort y hold", y_a, 5'b00011);
    check("abort z hold", z_a, 1);
    en_a = 1'b1;
    t_en = $time;
    win(0, 7, 7, 5'b00000, 0, 0, 0);
    check("restart window cycles", 32'((t_rv - t_en) / 10), 257);
    win(0, 55, 55, 5'b11111, 0, 0, 0);
    win(0, 49, 49, 5'b11111, 1, 0, 0);
    win(0, 49, 49, 5'b11111, 1, 0, 0);
    win(0, 49, 49, 5'b11111, 1, 1, 0);
    pulses(0, 10);
    rst_n = 1'b0;
    #1;
    check("async rst flow_rate", rate_a, 0);
    check("async rst y", y_a, 0);
    check("async rst z", z_a, 0);
    check("async rst z_alarm", za_a, 0);
    check("async rst overflow", ov_a, 0);
    check("async rst rate_valid", rv_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win(0, 3, 3, 5'b00000, 0, 0, 0);
    en_a = 1'b0;
    en_b = 1'b1;
    win(1, 260, 255, 5'b11111, 0, 0, 1);
    win(1, 10, 10, 5'b00001, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
